// File: rtl/xdma_from_remote_rx.sv
// -----------------------------------------------------------------------------
// xdma_from_remote_rx
//
// Receive-side demultiplexer for inter-cluster XDMA traffic. Incoming 512-bit
// write beats from a remote cluster are routed by address window to one of
// four targets:
//   - Finish : single-word window, unpacked into a {dma_id, from} FIFO
//   - Grant  : single-word window, unpacked into a {dma_id, from} FIFO
//   - Cfg    : single-word window, one full-word cfg image held until popped
//   - Data   : address range, forwarded beat-by-beat through a register slice
// Beats that hit no window, and surplus beats of single-word bursts, are
// accepted, dropped, and flagged with a one-cycle decode_err_o pulse.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   rx_valid_i/rx_ready_o         incoming beat handshake
//   rx_addr_i                     target address (first beat of a burst only)
//   rx_data_i, rx_last_i          beat payload and end-of-burst marker
//   grant_valid_o/grant_ready_i   grant FIFO head handshake, grant_o = head
//   finish_valid_o/finish_ready_i finish FIFO head handshake, finish_o = head
//   cfg_valid_o/cfg_ready_i       cfg register handshake, cfg_o = cfg image
//   data_valid_o/data_ready_i     data stream handshake, data_o/data_last_o
//   data_beat_cnt_o               accepted beats of the current data burst
//   decode_err_o                  one-cycle pulse per dropped beat
// -----------------------------------------------------------------------------

// Small message FIFO holding unpacked {dma_id, from} records.
// space_o already accounts for a pop in the same cycle so a full FIFO can
// accept a push while its head is being drained.
module xdma_frr_msg_fifo #(
   parameter int unsigned Depth = 2,
   parameter int unsigned Width = 56
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   output logic             space_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [Width-1:0] data_o
);
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);
   localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);
   localparam logic [CntW-1:0] CntFull = CntW'(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             pop;

   assign valid_o = (cnt_q != '0);
   assign pop     = valid_o & ready_i;
   assign space_o = (cnt_q != CntFull) | pop;
   assign data_o  = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_i) begin
         wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push_i, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // One register per entry; each only loads when the write pointer selects it.
   generate
      for (genvar gi = 0; gi < Depth; gi++) begin : g_entry
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               mem_q[gi] <= '0;
            end else if (push_i && (wr_ptr_q == PtrW'(gi))) begin
               mem_q[gi] <= data_i;
            end
         end
      end
   endgenerate
endmodule

module xdma_from_remote_rx #(
   parameter logic [47:0] FinishBase   = 48'h0,
   parameter logic [47:0] GrantBase    = 48'h40,
   parameter logic [47:0] CfgBase      = 48'h80,
   parameter logic [47:0] DataStart    = 48'h1000,
   parameter logic [47:0] DataEnd      = 48'h2000,
   parameter int unsigned MsgFifoDepth = 2
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         rx_valid_i,
   output logic         rx_ready_o,
   input  logic [47:0]  rx_addr_i,
   input  logic [511:0] rx_data_i,
   input  logic         rx_last_i,
   output logic         grant_valid_o,
   input  logic         grant_ready_i,
   output logic [55:0]  grant_o,
   output logic         finish_valid_o,
   input  logic         finish_ready_i,
   output logic [55:0]  finish_o,
   output logic         cfg_valid_o,
   input  logic         cfg_ready_i,
   output logic [511:0] cfg_o,
   output logic         data_valid_o,
   input  logic         data_ready_i,
   output logic [511:0] data_o,
   output logic         data_last_o,
   output logic [18:0]  data_beat_cnt_o,
   output logic         decode_err_o
);
   typedef enum logic [0:0] {
      S_IDLE,
      S_BURST
   } state_e;

   typedef enum logic [2:0] {
      T_NONE,
      T_FINISH,
      T_GRANT,
      T_CFG,
      T_DATA
   } tgt_e;

   localparam logic [18:0] CntMax = '1;

   state_e state_q, state_d;
   tgt_e   tgt_q, tgt_d;
   tgt_e   dec_tgt;
   tgt_e   cur_tgt;
   logic   first_beat;
   logic   accept;
   logic   rx_ready;

   logic   grant_push, finish_push;
   logic   grant_space, finish_space;
   logic   drop;

   logic [55:0]  msg_word;

   logic         cfg_valid_q, cfg_valid_d;
   logic [511:0] cfg_q, cfg_d;
   logic         data_valid_q, data_valid_d;
   logic [511:0] data_q, data_d;
   logic         data_last_q, data_last_d;
   logic [18:0]  beat_cnt_q, beat_cnt_d;
   logic         err_q, err_d;

   // ---------------------------------------------------------------- decode
   // Single-word windows are compared on the 64-byte line address and win
   // over the data range when they overlap.
   always_comb begin
      dec_tgt = T_NONE;
      if (rx_addr_i[47:6] == FinishBase[47:6]) begin
         dec_tgt = T_FINISH;
      end else if (rx_addr_i[47:6] == GrantBase[47:6]) begin
         dec_tgt = T_GRANT;
      end else if (rx_addr_i[47:6] == CfgBase[47:6]) begin
         dec_tgt = T_CFG;
      end else if ((rx_addr_i >= DataStart) && (rx_addr_i < DataEnd)) begin
         dec_tgt = T_DATA;
      end
   end

   assign first_beat = (state_q == S_IDLE);
   assign cur_tgt    = first_beat ? dec_tgt : tgt_q;

   // --------------------------------------------------------------- ready
   // Continuation beats of single-word targets are discarded, so they never
   // need to wait for room in the FIFO or cfg register.
   always_comb begin
      rx_ready = 1'b1;
      case (cur_tgt)
         T_FINISH: rx_ready = first_beat ? finish_space : 1'b1;
         T_GRANT:  rx_ready = first_beat ? grant_space : 1'b1;
         T_CFG:    rx_ready = first_beat ? (~cfg_valid_q | cfg_ready_i) : 1'b1;
         T_DATA:   rx_ready = ~data_valid_q | data_ready_i;
         default:  rx_ready = 1'b1;
      endcase
   end

   assign rx_ready_o = rx_ready;
   assign accept     = rx_valid_i & rx_ready;

   assign grant_push  = accept & first_beat & (cur_tgt == T_GRANT);
   assign finish_push = accept & first_beat & (cur_tgt == T_FINISH);
   assign drop        = accept & ((cur_tgt == T_NONE) |
                                  (~first_beat & (cur_tgt != T_DATA)));

   // {dma_id, from}; the reserved bits below 456 are discarded.
   assign msg_word = rx_data_i[511:456];

   // ----------------------------------------------------------------- FSM
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         tgt_q   <= T_NONE;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      case (state_q)
         S_IDLE: begin
            if (accept && !rx_last_i) begin
               state_d = S_BURST;
               tgt_d   = dec_tgt;
            end
         end
         S_BURST: begin
            if (accept && rx_last_i) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------- message FIFOs
   xdma_frr_msg_fifo #(
      .Depth (MsgFifoDepth),
      .Width (56)
   ) u_grant_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (grant_push),
      .data_i  (msg_word),
      .space_o (grant_space),
      .valid_o (grant_valid_o),
      .ready_i (grant_ready_i),
      .data_o  (grant_o)
   );

   xdma_frr_msg_fifo #(
      .Depth (MsgFifoDepth),
      .Width (56)
   ) u_finish_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (finish_push),
      .data_i  (msg_word),
      .space_o (finish_space),
      .valid_o (finish_valid_o),
      .ready_i (finish_ready_i),
      .data_o  (finish_o)
   );

   // ------------------------------------------- cfg, data slice, counters
   always_comb begin
      cfg_valid_d  = cfg_valid_q;
      cfg_d        = cfg_q;
      data_valid_d = data_valid_q;
      data_d       = data_q;
      data_last_d  = data_last_q;
      beat_cnt_d   = beat_cnt_q;
      err_d        = drop;

      // Pop first so a load in the same cycle wins.
      if (cfg_valid_q && cfg_ready_i) begin
         cfg_valid_d = 1'b0;
      end
      if (accept && first_beat && (cur_tgt == T_CFG)) begin
         cfg_valid_d = 1'b1;
         cfg_d       = rx_data_i;
      end

      if (data_valid_q && data_ready_i) begin
         data_valid_d = 1'b0;
      end
      if (accept && (cur_tgt == T_DATA)) begin
         data_valid_d = 1'b1;
         data_d       = rx_data_i;
         data_last_d  = rx_last_i;
         if (rx_last_i) begin
            beat_cnt_d = '0;
         end else if (beat_cnt_q != CntMax) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cfg_valid_q  <= 1'b0;
         cfg_q        <= '0;
         data_valid_q <= 1'b0;
         data_q       <= '0;
         data_last_q  <= 1'b0;
         beat_cnt_q   <= '0;
         err_q        <= 1'b0;
      end else begin
         cfg_valid_q  <= cfg_valid_d;
         cfg_q        <= cfg_d;
         data_valid_q <= data_valid_d;
         data_q       <= data_d;
         data_last_q  <= data_last_d;
         beat_cnt_q   <= beat_cnt_d;
         err_q        <= err_d;
      end
   end

   assign cfg_valid_o     = cfg_valid_q;
   assign cfg_o           = cfg_q;
   assign data_valid_o    = data_valid_q;
   assign data_o          = data_q;
   assign data_last_o     = data_last_q;
   assign data_beat_cnt_o = beat_cnt_q;
   assign decode_err_o    = err_q;
endmodule

// File: tb/tb_xdma_from_remote_rx.sv
// -----------------------------------------------------------------------------
// Bench for xdma_from_remote_rx: directed stimulus in one initial block,
// expected outputs queued when beats are driven and popped by a negedge
// monitor when the DUT hands them off.
// -----------------------------------------------------------------------------
module tb_xdma_from_remote_rx;
   logic         clk = 1'b0;
   logic         rst;
   logic         rx_valid;
   logic         rx_ready;
   logic [47:0]  rx_addr;
   logic [511:0] rx_data;
   logic         rx_last;
   logic         grant_valid, grant_ready;
   logic [55:0]  grant_w;
   logic         finish_valid, finish_ready;
   logic [55:0]  finish_w;
   logic         cfg_valid, cfg_ready;
   logic [511:0] cfg_w;
   logic         data_valid, data_ready;
   logic [511:0] data_w;
   logic         data_last;
   logic [18:0]  beat_cnt;
   logic         decode_err;

   int checks = 0;
   int failures = 0;
   int err_count = 0;

   logic [55:0]  grant_exp[$];
   logic [55:0]  finish_exp[$];
   logic [511:0] cfg_exp[$];
   logic [512:0] data_exp[$];

   always #5 clk = ~clk;

   xdma_from_remote_rx dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .rx_valid_i      (rx_valid),
      .rx_ready_o      (rx_ready),
      .rx_addr_i       (rx_addr),
      .rx_data_i       (rx_data),
      .rx_last_i       (rx_last),
      .grant_valid_o   (grant_valid),
      .grant_ready_i   (grant_ready),
      .grant_o         (grant_w),
      .finish_valid_o  (finish_valid),
      .finish_ready_i  (finish_ready),
      .finish_o        (finish_w),
      .cfg_valid_o     (cfg_valid),
      .cfg_ready_i     (cfg_ready),
      .cfg_o           (cfg_w),
      .data_valid_o    (data_valid),
      .data_ready_i    (data_ready),
      .data_o          (data_w),
      .data_last_o     (data_last),
      .data_beat_cnt_o (beat_cnt),
      .decode_err_o    (decode_err)
   );

   task automatic check(input string tag, input logic [575:0] obs, input logic [575:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] mk_msg(input logic [7:0] id, input logic [47:0] from);
      logic [511:0] v;
      v = '0;
      v[511:504] = id;
      v[503:456] = from;
      v[31:0]    = 32'hDEAD_BEEF;   // reserved bits must be ignored
      return v;
   endfunction

   // Drive one beat and hold it until accepted (bounded).
   task automatic send_beat(input logic [47:0] a, input logic [511:0] d, input logic l);
      int n;
      n = 0;
      rx_valid = 1'b1;
      rx_addr  = a;
      rx_data  = d;
      rx_last  = l;
      forever begin
         @(negedge clk);
         if (rx_ready === 1'b1) break;
         n++;
         if (n > 200) begin
            check("rx_accept_timeout", 576'(rx_ready), 576'(1));
            break;
         end
      end
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Output monitor / scoreboard.
   always @(negedge clk) begin
      if (decode_err === 1'b1) err_count++;
      if (grant_valid === 1'b1 && grant_ready === 1'b1) begin
         checks++;
         assert (grant_exp.size() != 0) else begin
            failures++;
            $error("FAIL grant_unexpected observed=%0h expected=none", grant_w);
         end
         if (grant_exp.size() != 0) check("grant_pop", 576'(grant_w), 576'(grant_exp.pop_front()));
      end
      if (finish_valid === 1'b1 && finish_ready === 1'b1) begin
         checks++;
         assert (finish_exp.size() != 0) else begin
            failures++;
            $error("FAIL finish_unexpected observed=%0h expected=none", finish_w);
         end
         if (finish_exp.size() != 0) check("finish_pop", 576'(finish_w), 576'(finish_exp.pop_front()));
      end
      if (cfg_valid === 1'b1 && cfg_ready === 1'b1) begin
         checks++;
         assert (cfg_exp.size() != 0) else begin
            failures++;
            $error("FAIL cfg_unexpected observed=%0h expected=none", cfg_w);
         end
         if (cfg_exp.size() != 0) check("cfg_pop", 576'(cfg_w), 576'(cfg_exp.pop_front()));
      end
      if (data_valid === 1'b1 && data_ready === 1'b1) begin
         checks++;
         assert (data_exp.size() != 0) else begin
            failures++;
            $error("FAIL data_unexpected observed=%0h expected=none", data_w);
         end
         if (data_exp.size() != 0) check("data_pop", 576'({data_last, data_w}), 576'(data_exp.pop_front()));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int e0;
      int n;
      rst = 1'b1;
      rx_valid = 1'b0;
      rx_addr = '0;
      rx_data = '0;
      rx_last = 1'b0;
      grant_ready = 1'b0;
      finish_ready = 1'b0;
      cfg_ready = 1'b0;
      data_ready = 1'b0;
      step(3);
      rst = 1'b0;
      step(1);

      // Reset state
      check("rst_grant_valid", 576'(grant_valid), 576'(0));
      check("rst_finish_valid", 576'(finish_valid), 576'(0));
      check("rst_cfg_valid", 576'(cfg_valid), 576'(0));
      check("rst_data_valid", 576'(data_valid), 576'(0));
      check("rst_beat_cnt", 576'(beat_cnt), 576'(0));
      check("rst_decode_err", 576'(decode_err), 576'(0));

      // Grant single beat
      grant_exp.push_back(56'h5A_0000_1234_5678);
      send_beat(48'h40, mk_msg(8'h5A, 48'h0000_1234_5678), 1'b1);
      check("grant_valid", 576'(grant_valid), 576'(1));
      check("grant_word", 576'(grant_w), 576'(56'h5A_0000_1234_5678));
      check("grant_finish_valid", 576'(finish_valid), 576'(0));
      check("grant_cfg_valid", 576'(cfg_valid), 576'(0));
      check("grant_data_valid", 576'(data_valid), 576'(0));
      grant_ready = 1'b1;
      step(1);
      grant_ready = 1'b0;
      check("grant_drained", 576'(grant_valid), 576'(0));

      // Finish FIFO fill and drain in order
      for (int k = 1; k <= 2; k++) begin
         finish_exp.push_back({8'(k), 48'hABC0 + 48'(k)});
         send_beat(48'h0, mk_msg(8'(k), 48'hABC0 + 48'(k)), 1'b1);
      end
      rx_valid = 1'b1;
      rx_addr = 48'h0;
      rx_data = mk_msg(8'd3, 48'hABC3);
      rx_last = 1'b1;
      @(negedge clk);
      check("finish_full_ready", 576'(rx_ready), 576'(0));
      @(posedge clk);
      #1;
      finish_ready = 1'b1;
      finish_exp.push_back({8'd3, 48'hABC3});
      send_beat(48'h0, mk_msg(8'd3, 48'hABC3), 1'b1);
      step(4);
      finish_ready = 1'b0;
      check("finish_all_popped", 576'(finish_exp.size()), 576'(0));

      // Data burst with toggling ready and beat counter
      data_ready = 1'b1;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               data_ready = ~data_ready;
               @(posedge clk);
               #1;
            end
            data_ready = 1'b1;
         end
         begin
            for (int k = 0; k < 4; k++) begin
               check("data_beat_cnt", 576'(beat_cnt), 576'(k));
               data_exp.push_back({(k == 3), 512'(k)});
               send_beat(48'h1000 + 48'(k * 64), 512'(k), (k == 3));
            end
            check("data_beat_cnt_wrap", 576'(beat_cnt), 576'(0));
         end
      join
      n = 0;
      while (data_valid === 1'b1 && n < 50) begin
         step(1);
         n++;
      end
      check("data_all_popped", 576'(data_exp.size()), 576'(0));

      // Cfg stall then same-cycle pop and reload
      cfg_ready = 1'b0;
      data_ready = 1'b0;
      cfg_exp.push_back({16{32'hC0F1_0001}});
      send_beat(48'h80, {16{32'hC0F1_0001}}, 1'b1);
      check("cfg_valid", 576'(cfg_valid), 576'(1));
      rx_valid = 1'b1;
      rx_addr = 48'h80;
      rx_data = {16{32'hC0F1_0002}};
      rx_last = 1'b1;
      @(negedge clk);
      check("cfg_stall_ready", 576'(rx_ready), 576'(0));
      @(posedge clk);
      #1;
      check("cfg_held", 576'(cfg_w), 576'({16{32'hC0F1_0001}}));
      cfg_ready = 1'b1;
      cfg_exp.push_back({16{32'hC0F1_0002}});
      send_beat(48'h80, {16{32'hC0F1_0002}}, 1'b1);
      check("cfg_second_loaded", 576'(cfg_w), 576'({16{32'hC0F1_0002}}));
      step(1);
      cfg_ready = 1'b0;
      check("cfg_all_popped", 576'(cfg_exp.size()), 576'(0));

      // Decode errors: NONE beat, then 2-beat grant burst
      e0 = err_count;
      send_beat(48'h3000, 512'h1, 1'b1);
      check("none_err_pulse", 576'(decode_err), 576'(1));
      grant_exp.push_back({8'h11, 48'h0000_0000_0011});
      send_beat(48'h40, mk_msg(8'h11, 48'h11), 1'b0);
      send_beat(48'h5555, mk_msg(8'h22, 48'h22), 1'b1);
      step(2);
      check("decode_err_count", 576'(err_count - e0), 576'(2));
      grant_ready = 1'b1;
      step(3);
      grant_ready = 1'b0;
      check("grant_one_pushed", 576'(grant_exp.size()), 576'(0));
      check("grant_empty_after", 576'(grant_valid), 576'(0));

      // Reset in the middle of a data burst
      data_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         data_exp.push_back({1'b0, 512'(16 + k)});
         send_beat(48'h1800, 512'(16 + k), 1'b0);
      end
      check("burst_cnt_before_rst", 576'(beat_cnt), 576'(2));
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      check("mid_rst_data_valid", 576'(data_valid), 576'(0));
      check("mid_rst_cfg_valid", 576'(cfg_valid), 576'(0));
      check("mid_rst_grant_valid", 576'(grant_valid), 576'(0));
      check("mid_rst_finish_valid", 576'(finish_valid), 576'(0));
      check("mid_rst_beat_cnt", 576'(beat_cnt), 576'(0));
      cfg_exp.push_back({16{32'hC0F1_0003}});
      send_beat(48'h80, {16{32'hC0F1_0003}}, 1'b1);
      check("post_rst_cfg_valid", 576'(cfg_valid), 576'(1));
      check("post_rst_data_valid", 576'(data_valid), 576'(0));
      cfg_ready = 1'b1;
      step(1);
      cfg_ready = 1'b0;
      step(2);

      check("final_grant_q", 576'(grant_exp.size()), 576'(0));
      check("final_finish_q", 576'(finish_exp.size()), 576'(0));
      check("final_cfg_q", 576'(cfg_exp.size()), 576'(0));
      check("final_data_q", 576'(data_exp.size()), 576'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
